// File: rtl/seqdet_pkg.sv
// seqdet_pkg: parity state and constants shared across the sequence-detector family
package seqdet_pkg;
  typedef enum logic {S_EVEN = 1'b0, S_ODD = 1'b1} parity_e;
  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD = 1'b1;
  function automatic parity_e parity_step(input parity_e p, input logic b);
    return b ? (p == S_EVEN ? S_ODD : S_EVEN) : p;
  endfunction
endpackage

// File: rtl/sat_run_counter.sv
// sat_run_counter: saturating counter with clear > hold > zero > increment priority
module sat_run_counter #(
  parameter int MAX = 2,
  parameter int W = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         zero_i,
  input  logic         hold_i,
  input  logic         clear_i,
  output logic [W-1:0] cnt_o,
  output logic         at_max_o
);
  logic [W-1:0] cnt_q, cnt_d;
  // next count: clear wins, then hold, then zero, then saturating increment
  always_comb cnt_d = clear_i ? '0 : hold_i ? cnt_q : zero_i ? '0 : (inc_i && cnt_q != W'(MAX)) ? cnt_q + 1'b1 : cnt_q;
  // count register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
  assign at_max_o = cnt_q == W'(MAX);
endmodule

// File: rtl/parity_zero_run_detector.sv
// parity_zero_run_detector: flags a saturated zero run under matching 1s parity; PZRD_MATCH_COUNT_EN adds a detection counter
module parity_zero_run_detector
  import seqdet_pkg::*;
#(
  parameter int RUN_LEN = 2,
  parameter bit PARITY_MODE = PARITY_EVEN,
  parameter int RUN_W = $clog2(RUN_LEN + 1),
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  input  logic             x,
  output logic             y,
  output logic             parity,
  output logic [RUN_W-1:0] run_len
`ifdef PZRD_MATCH_COUNT_EN
  ,
  output logic [CNT_W-1:0] match_cnt
`endif
);
  parity_e parity_q, parity_d;
  logic y_q, y_d, at_max;
  sat_run_counter #(.MAX(RUN_LEN), .W(RUN_W)) u_run (
    .clk(clk),
    .rst_n(reset_n),
    .inc_i(~x),
    .zero_i(x),
    .hold_i(~en),
    .clear_i(clr),
    .cnt_o(run_len),
    .at_max_o(at_max)
  );
  // next parity and detection; a sampled 0 reaches RUN_LEN when the run is already at RUN_LEN-1 or saturated
  always_comb begin
    parity_d = clr ? S_EVEN : en ? parity_step(parity_q, x) : parity_q;
    y_d = clr ? 1'b0 : en ? (!x && (at_max || run_len == RUN_W'(RUN_LEN - 1)) && parity_d == parity_e'(PARITY_MODE)) : y_q;
  end
  // parity state and detection flag registers
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      parity_q <= S_EVEN;
      y_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
      y_q <= y_d;
    end
  assign y = y_q;
  assign parity = parity_q;
`ifdef PZRD_MATCH_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // count rising edges of y, saturating at all-ones
  always_comb cnt_d = clr ? '0 : (y_d && !y_q && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  // match counter register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign match_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_parity_zero_run_detector.sv
// tb_parity_zero_run_detector: directed checks over four configurations sharing one stimulus stream
module tb_parity_zero_run_detector;
  logic clk = 1'b0;
  logic reset_n, en, clr, x;
  logic y_a, y_b, y_c, y_d;
  logic par_a, par_b, par_c, par_d;
  logic [1:0] run_a, run_b, run_d;
  logic [2:0] run_c;
  logic [7:0] cnt_a, cnt_b, cnt_c;
  logic [1:0] cnt_d;
  int n_run = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  parity_zero_run_detector #(.RUN_LEN(2), .PARITY_MODE(1'b0)) dut_a (
    .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .x(x), .y(y_a), .parity(par_a), .run_len(run_a)
`ifdef PZRD_MATCH_COUNT_EN
    , .match_cnt(cnt_a)
`endif
  );
  parity_zero_run_detector #(.RUN_LEN(2), .PARITY_MODE(1'b1)) dut_b (
    .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .x(x), .y(y_b), .parity(par_b), .run_len(run_b)
`ifdef PZRD_MATCH_COUNT_EN
    , .match_cnt(cnt_b)
`endif
  );
  parity_zero_run_detector #(.RUN_LEN(4), .PARITY_MODE(1'b0)) dut_c (
    .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .x(x), .y(y_c), .parity(par_c), .run_len(run_c)
`ifdef PZRD_MATCH_COUNT_EN
    , .match_cnt(cnt_c)
`endif
  );
  parity_zero_run_detector #(.RUN_LEN(2), .PARITY_MODE(1'b0), .CNT_W(2)) dut_d (
    .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .x(x), .y(y_d), .parity(par_d), .run_len(run_d)
`ifdef PZRD_MATCH_COUNT_EN
    , .match_cnt(cnt_d)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic send(input logic b);
    en = 1'b1;
    clr = 1'b0;
    x = b;
    @(posedge clk);
    #1;
  endtask
  task automatic hold(input logic b);
    en = 1'b0;
    clr = 1'b0;
    x = b;
    @(posedge clk);
    #1;
  endtask
  task automatic do_clr();
    en = 1'b1;
    clr = 1'b1;
    x = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask
  initial begin
    logic [15:0] seq3, exp3;
    logic [7:0] seq4, exp4;
    logic [2:0] run4 [8];
    logic [3:0] seq2;
    logic [1:0] run2 [4];
    logic [3:0] exp2;
    // reset held with x=1 and en=1 across two edges
    reset_n = 1'b0;
    en = 1'b1;
    clr = 1'b0;
    x = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_y", y_a, 0);
    chk("rst_parity", par_a, 0);
    chk("rst_run", run_a, 0);
    reset_n = 1'b1;
    #2;
    chk("rel_y", y_a, 0);
    chk("rel_parity", par_a, 0);
    chk("rel_run", run_a, 0);
    // defaults: 0,0,0,1
    seq2 = 4'b0001;
    exp2 = 4'b0110;
    run2 = '{2'd1, 2'd2, 2'd2, 2'd0};
    for (int i = 0; i < 4; i++) begin
      send(seq2[3-i]);
      chk($sformatf("t2_y%0d", i + 1), y_a, exp2[3-i]);
      chk($sformatf("t2_run%0d", i + 1), run_a, run2[i]);
    end
    chk("t2_parity", par_a, 1);
    // odd-parity mode
    do_clr();
    chk("clr_parity", par_b, 0);
    seq3 = 16'b1101_0001_1000_1100;
    exp3 = 16'b0000_0110_0011_0001;
    for (int i = 0; i < 16; i++) begin
      send(seq3[15-i]);
      chk($sformatf("t3_y%0d", i + 1), y_b, exp3[15-i]);
    end
`ifdef PZRD_MATCH_COUNT_EN
    chk("t3_cnt", cnt_b, 3);
`endif
    // RUN_LEN=4, entered with odd parity so the 1 at bit 4 makes it even
    do_clr();
    send(1'b1);
    seq4 = 8'b0001_0000;
    exp4 = 8'b0000_0001;
    run4 = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    for (int i = 0; i < 8; i++) begin
      send(seq4[7-i]);
      chk($sformatf("t4_y%0d", i + 1), y_c, exp4[7-i]);
      chk($sformatf("t4_run%0d", i + 1), run_c, run4[i]);
    end
    chk("t4_parity", par_c, 0);
    // enable low holds everything, then clear while y is high
    do_clr();
    send(1'b0);
    send(1'b0);
    chk("t5_pre_y", y_a, 1);
    for (int i = 0; i < 3; i++) begin
      hold(i[0] ? 1'b0 : 1'b1);
      chk($sformatf("t5_hold_y%0d", i), y_a, 1);
      chk($sformatf("t5_hold_run%0d", i), run_a, 2);
      chk($sformatf("t5_hold_par%0d", i), par_a, 0);
    end
    en = 1'b0;
    do_clr();
    chk("t5_clr_y", y_a, 0);
    chk("t5_clr_run", run_a, 0);
    chk("t5_clr_par", par_a, 0);
`ifdef PZRD_MATCH_COUNT_EN
    chk("t5_clr_cnt", cnt_d, 0);
`endif
    // asynchronous reset drops y between edges
    send(1'b0);
    send(1'b0);
    chk("t6_pre_y", y_a, 1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("t6_async_y", y_a, 0);
    chk("t6_async_run", run_a, 0);
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    // five detections: 2-bit counter saturates, 8-bit counter reaches 5
    for (int i = 0; i < 5; i++) begin
      send(1'b0);
      send(1'b0);
      chk($sformatf("t6_det%0d", i), y_d, 1);
      send(1'b1);
      send(1'b1);
    end
`ifdef PZRD_MATCH_COUNT_EN
    chk("t6_cnt_sat", cnt_d, 3);
    chk("t6_cnt_wide", cnt_a, 5);
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
